regfile: RTL and testbench



---
 rtl/regfile.sv | 83 ++++++++
 tb/tb_regfile.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile: 32 x 32-bit general-purpose register file for the 5-stage CPU.
// Takes one write per cycle from writeback. Serves two combinational read
// ports to decode, with same-cycle write-to-read bypass. r0 always reads zero.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2
);

  // Storage view used by the read muxes; entry 0 is a constant zero, not a flop.
  logic [31:0] regs [0:31];

  assign regs[0] = 32'h0000_0000;

  genvar gi;

  // One flop per architectural register r1..r31.
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      logic [31:0] reg_d;
      logic [31:0] reg_q;

      // Next state: reset clears (and drops any same-cycle write), else a matching write loads.
      always_comb begin
        reg_d = reg_q;
        if (rst) begin
          reg_d = 32'h0000_0000;
        end else if (we && (waddr == 5'(gi))) begin
          reg_d = wdata;
        end
      end

      // Register state update.
      always_ff @(posedge clk) begin
        reg_q <= reg_d;
      end

      assign regs[gi] = reg_q;
    end
  endgenerate

  // Both read ports share identical logic; gather them into small arrays.
  logic        rd_en   [0:1];
  logic [4:0]  rd_addr [0:1];
  logic [31:0] rd_data [0:1];

  assign rd_en[0]   = re1;
  assign rd_en[1]   = re2;
  assign rd_addr[0] = raddr1;
  assign rd_addr[1] = raddr2;
  assign rdata1     = rd_data[0];
  assign rdata2     = rd_data[1];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      // Read mux. The enable is tested before the address so an unknown
      // address on a disabled port can never leak into its output.
      always_comb begin
        rd_data[gi] = 32'h0000_0000;
        if (rst) begin
          rd_data[gi] = 32'h0000_0000;
        end else if (!rd_en[gi]) begin
          rd_data[gi] = 32'h0000_0000;
        end else if (rd_addr[gi] == 5'd0) begin
          rd_data[gi] = 32'h0000_0000;
        end else if (we && (rd_addr[gi] == waddr)) begin
          rd_data[gi] = wdata;
        end else begin
          rd_data[gi] = regs[rd_addr[gi]];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed and randomized checks of the regfile block.
// Inputs change on the falling edge; outputs are checked 1 ns later,
// well before the next rising edge commits the write.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int n_cmp;
  int n_bad;

  // Reference contents of r0..r31 as the bench expects them.
  logic [31:0] model [0:31];

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value for the currently driven inputs.
  function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
    if (rst)                  return 32'h0;
    if (a == 5'd0)            return 32'h0;
    if (!en)                  return 32'h0;
    if (we && (a == waddr))   return wdata;
    return model[a];
  endfunction

  // Let the next rising edge commit the driven write, mirroring it into the model.
  task automatic apply_edge();
    if (rst) begin
      for (int k = 0; k < 32; k++) model[k] = 32'h0;
    end else if (we && (waddr != 5'd0)) begin
      model[waddr] = wdata;
    end
    @(posedge clk);
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #1;
  endtask

  task automatic test_reset();
    // Power-on reset so the model and DUT start in the same state.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd2);
    n_cmp++;
    if (rdata1 !== 32'h0) begin
      n_bad++; $display("FAIL reset_por_rd1: got %h want %h", rdata1, 32'h0);
    end
    apply_edge();
    // Write r5 and confirm it landed.
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    apply_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
    n_cmp++;
    if (rdata1 !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL reset_pre_r5: got %h want %h", rdata1, 32'hDEADBEEF);
    end
    apply_edge();
    // Reset with a competing write to r6 in the same cycle.
    drive(1'b1, 1'b1, 5'd6, 32'hCAFEF00D, 1'b1, 5'd5, 1'b1, 5'd6);
    n_cmp++;
    if (rdata1 !== 32'h0) begin
      n_bad++; $display("FAIL reset_during_rd1: got %h want %h", rdata1, 32'h0);
    end
    n_cmp++;
    if (rdata2 !== 32'h0) begin
      n_bad++; $display("FAIL reset_during_rd2: got %h want %h", rdata2, 32'h0);
    end
    apply_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd6);
    n_cmp++;
    if (rdata1 !== 32'h0) begin
      n_bad++; $display("FAIL reset_after_r5: got %h want %h", rdata1, 32'h0);
    end
    n_cmp++;
    if (rdata2 !== 32'h0) begin
      n_bad++; $display("FAIL reset_dropped_r6: got %h want %h", rdata2, 32'h0);
    end
    apply_edge();
  endtask

  task automatic test_r0();
    drive(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b1, 5'd0);
    n_cmp++;
    if (rdata1 !== 32'h0) begin
      n_bad++; $display("FAIL r0_bypass_rd1: got %h want %h", rdata1, 32'h0);
    end
    n_cmp++;
    if (rdata2 !== 32'h0) begin
      n_bad++; $display("FAIL r0_bypass_rd2: got %h want %h", rdata2, 32'h0);
    end
    apply_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
    n_cmp++;
    if (rdata1 !== 32'h0) begin
      n_bad++; $display("FAIL r0_stored_rd1: got %h want %h", rdata1, 32'h0);
    end
    n_cmp++;
    if (rdata2 !== 32'h0) begin
      n_bad++; $display("FAIL r0_stored_rd2: got %h want %h", rdata2, 32'h0);
    end
    apply_edge();
  endtask

  task automatic test_bypass();
    drive(1'b0, 1'b1, 5'd8, 32'h0BADF00D, 1'b0, 5'd0, 1'b0, 5'd0);
    apply_edge();
    drive(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 1'b1, 5'd8);
    n_cmp++;
    if (rdata1 !== 32'hA5A5A5A5) begin
      n_bad++; $display("FAIL bypass_rd1: got %h want %h", rdata1, 32'hA5A5A5A5);
    end
    n_cmp++;
    if (rdata2 !== 32'h0BADF00D) begin
      n_bad++; $display("FAIL bypass_old_r8: got %h want %h", rdata2, 32'h0BADF00D);
    end
    apply_edge();
    drive(1'b0, 1'b0, 5'd7, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0);
    n_cmp++;
    if (rdata1 !== 32'hA5A5A5A5) begin
      n_bad++; $display("FAIL bypass_stored_r7: got %h want %h", rdata1, 32'hA5A5A5A5);
    end
    apply_edge();
    // Same index on both ports while it is being overwritten.
    drive(1'b0, 1'b1, 5'd7, 32'h5A5A5A5A, 1'b1, 5'd7, 1'b1, 5'd7);
    n_cmp++;
    if (rdata1 !== 32'h5A5A5A5A) begin
      n_bad++; $display("FAIL bypass_both_rd1: got %h want %h", rdata1, 32'h5A5A5A5A);
    end
    n_cmp++;
    if (rdata2 !== 32'h5A5A5A5A) begin
      n_bad++; $display("FAIL bypass_both_rd2: got %h want %h", rdata2, 32'h5A5A5A5A);
    end
    apply_edge();
    // Back-to-back writes to the same index: last one wins.
    drive(1'b0, 1'b1, 5'd9, 32'h11112222, 1'b0, 5'd0, 1'b0, 5'd0);
    apply_edge();
    drive(1'b0, 1'b1, 5'd9, 32'h33334444, 1'b0, 5'd0, 1'b0, 5'd0);
    apply_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);
    n_cmp++;
    if (rdata1 !== 32'h33334444) begin
      n_bad++; $display("FAIL b2b_last_wins: got %h want %h", rdata1, 32'h33334444);
    end
    apply_edge();
  endtask

  task automatic test_read_enable();
    drive(1'b0, 1'b1, 5'd3, 32'h00000011, 1'b0, 5'd0, 1'b0, 5'd0);
    apply_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b0, 5'bxxxxx);
    n_cmp++;
    if (rdata1 !== 32'h0) begin
      n_bad++; $display("FAIL re1_off: got %h want %h", rdata1, 32'h0);
    end
    n_cmp++;
    if (rdata2 !== 32'h0) begin
      n_bad++; $display("FAIL re2_off_xaddr: got %h want %h", rdata2, 32'h0);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
    n_cmp++;
    if (rdata1 !== 32'h00000011) begin
      n_bad++; $display("FAIL re1_on: got %h want %h", rdata1, 32'h00000011);
    end
    n_cmp++;
    if (rdata2 !== 32'h00000011) begin
      n_bad++; $display("FAIL re2_on: got %h want %h", rdata2, 32'h00000011);
    end
    apply_edge();
  endtask

  task automatic test_sweep();
    logic [31:0] want1;
    logic [31:0] want2;
    logic [4:0]  a1;
    logic [4:0]  a2;
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 1'b0, 5'd0, 1'b0, 5'd0);
      apply_edge();
    end
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i);
      a2 = 5'(32 - i);
      want1 = (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
      want2 = (i == 0) ? 32'h0 : 32'(32 - i) * 32'h01010101;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, a1, 1'b1, a2);
      n_cmp++;
      if (rdata1 !== want1) begin
        n_bad++; $display("FAIL sweep_rd1 r%0d: got %h want %h", a1, rdata1, want1);
      end
      n_cmp++;
      if (rdata2 !== want2) begin
        n_bad++; $display("FAIL sweep_rd2 r%0d: got %h want %h", a2, rdata2, want2);
      end
    end
    apply_edge();
  endtask

  task automatic test_stall_random();
    logic [31:0] want1;
    logic [31:0] want2;
    int kind;
    int shown;
    shown = 0;
    for (int c = 0; c < 10000; c++) begin
      kind = int'($urandom_range(0, 9));
      @(negedge clk);
      rst    = ($urandom_range(0, 299) == 0);
      we     = (kind >= 2);
      waddr  = (kind == 2) ? 5'd0 : 5'($urandom_range(0, 31));
      wdata  = $urandom;
      re1    = ($urandom_range(0, 7) != 0);
      re2    = ($urandom_range(0, 7) != 0);
      // Bias reads toward the write index to exercise the bypass often.
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      #1;
      want1 = exp_rd(re1, raddr1);
      want2 = exp_rd(re2, raddr2);
      n_cmp++;
      if (rdata1 !== want1) begin
        n_bad++;
        if (shown < 20) $display("FAIL rand_rd1 cyc%0d r%0d: got %h want %h", c, raddr1, rdata1, want1);
        shown++;
      end
      n_cmp++;
      if (rdata2 !== want2) begin
        n_bad++;
        if (shown < 20) $display("FAIL rand_rd2 cyc%0d r%0d: got %h want %h", c, raddr2, rdata2, want2);
        shown++;
      end
      apply_edge();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
    rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
    test_reset();
    test_r0();
    test_bypass();
    test_read_enable();
    test_sweep();
    test_stall_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
